// File: rtl/mandel_scan_ctrl_pkg.sv
// Shared constants, FSM encoding and iteration-to-colour mapping for the
// Mandelbrot frame scan controller.
package mandel_scan_ctrl_pkg;

  // Default coordinate width: signed Q4.12 fixed point.
  localparam int DEF_N_BIT = 16;
  localparam int FRAC      = 12;
  // Default iteration counter width.
  localparam int DEF_W_IT  = 16;
  // Framebuffer geometry.
  localparam int PIX_X_W   = 9;
  localparam int PIX_Y_W   = 8;
  localparam int WD_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Points that never escaped map to colour 0; escaped points cycle through
  // colours 1..7 by iteration count.
  function automatic logic [WD_W-1:0] color_map(input logic [31:0] iter,
                                                input logic [31:0] max_it);
    if (iter >= max_it) color_map = '0;
    else                color_map = WD_W'(iter % 32'd7) + WD_W'(1);
  endfunction

endpackage

// File: rtl/mandel_scan_ctrl_if.sv
// Job / result handshake between the scan controller and the iteration engine.
interface mandel_scan_ctrl_if
  import mandel_scan_ctrl_pkg::*;
#(
  parameter int N_BIT = DEF_N_BIT,
  parameter int W_IT  = DEF_W_IT
) ();

  logic                    job_valid;
  logic                    job_ready;
  logic signed [N_BIT-1:0] job_cx;
  logic signed [N_BIT-1:0] job_cy;
  logic [W_IT-1:0]         job_max;
  logic                    res_valid;
  logic [W_IT-1:0]         res_iter;
  logic                    eng_abort;

  // Scan controller side.
  modport master (
    output job_valid, job_cx, job_cy, job_max, eng_abort,
    input  job_ready, res_valid, res_iter
  );

  // Iteration engine side.
  modport slave (
    input  job_valid, job_cx, job_cy, job_max, eng_abort,
    output job_ready, res_valid, res_iter
  );

endinterface

// File: rtl/mandel_color_map.sv
// Combinational translation of an engine iteration count into a pixel colour.
module mandel_color_map
  import mandel_scan_ctrl_pkg::*;
#(
  parameter int W_IT = DEF_W_IT
) (
  input  logic [W_IT-1:0] res_iter_i,
  input  logic [W_IT-1:0] max_i,
  output logic [WD_W-1:0] wd_o
);

  // Pure lookup, no state.
  assign wd_o = color_map(32'(res_iter_i), 32'(max_i));

endmodule

// File: rtl/mandel_scan_ctrl.sv
// Mandelbrot frame scan controller: walks the pixel grid column-major, hands
// one c coordinate at a time to the iteration engine and writes the coloured
// result to the framebuffer. A new cfg_start at any time restarts the frame.
module mandel_scan_ctrl
  import mandel_scan_ctrl_pkg::*;
#(
  parameter int N_BIT = DEF_N_BIT,
  parameter int W_IT  = DEF_W_IT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [PIX_X_W-1:0]      cfg_pix_x,
  input  logic [PIX_Y_W-1:0]      cfg_pix_y,
  input  logic signed [N_BIT-1:0] cfg_cxs,
  input  logic signed [N_BIT-1:0] cfg_cys,
  input  logic signed [N_BIT-1:0] cfg_dcx,
  input  logic signed [N_BIT-1:0] cfg_dcy,
  input  logic [W_IT-1:0]         cfg_max_iter,
  mandel_scan_ctrl_if.master      eng,
  output logic [PIX_X_W-1:0]      wx,
  output logic [PIX_Y_W-1:0]      wy,
  output logic [WD_W-1:0]         wd,
  output logic                    we,
  output logic                    busy,
  output logic                    done
);

  state_t                  state_q;

  // Latched frame configuration.
  logic [PIX_X_W-1:0]      pix_x_q;
  logic [PIX_Y_W-1:0]      pix_y_q;
  logic signed [N_BIT-1:0] cys_q;
  logic signed [N_BIT-1:0] dcx_q;
  logic signed [N_BIT-1:0] dcy_q;
  logic [W_IT-1:0]         max_q;

  // Current pixel and its c coordinate.
  logic [PIX_X_W-1:0]      px_q;
  logic [PIX_Y_W-1:0]      py_q;
  logic signed [N_BIT-1:0] cx_q;
  logic signed [N_BIT-1:0] cy_q;

  // Registered outputs.
  logic                    job_valid_q;
  logic                    abort_q;
  logic                    we_q;
  logic [PIX_X_W-1:0]      wx_q;
  logic [PIX_Y_W-1:0]      wy_q;
  logic [WD_W-1:0]         wd_q;
  logic                    busy_q;
  logic                    done_q;

  // Next pixel in scan order.
  logic [PIX_X_W-1:0]      px_d;
  logic [PIX_Y_W-1:0]      py_d;
  logic signed [N_BIT-1:0] cx_d;
  logic signed [N_BIT-1:0] cy_d;
  logic                    last_pix_d;

  logic                    cfg_empty;
  logic [WD_W-1:0]         wd_map;

  assign cfg_empty = (cfg_pix_x == '0) || (cfg_pix_y == '0);

  mandel_color_map #(
    .W_IT (W_IT)
  ) u_color_map (
    .res_iter_i (eng.res_iter),
    .max_i      (max_q),
    .wd_o       (wd_map)
  );

  // Column-major advance: rows within a column first, wrapping adds on c.
  always_comb begin
    px_d       = px_q;
    py_d       = py_q + PIX_Y_W'(1);
    cx_d       = cx_q;
    cy_d       = cy_q + dcy_q;
    last_pix_d = 1'b0;
    if (py_q == pix_y_q - PIX_Y_W'(1)) begin
      py_d       = '0;
      cy_d       = cys_q;
      px_d       = px_q + PIX_X_W'(1);
      cx_d       = cx_q + dcx_q;
      last_pix_d = (px_q == pix_x_q - PIX_X_W'(1));
    end
  end

  // Scan FSM with all outputs registered; cfg_start overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      cys_q       <= '0;
      dcx_q       <= '0;
      dcy_q       <= '0;
      max_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      job_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      we_q        <= 1'b0;
      wx_q        <= '0;
      wy_q        <= '0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      we_q    <= 1'b0;
      if (cfg_start) begin
        // Only a job the engine has actually accepted needs aborting.
        abort_q <= (state_q == S_WAIT);
        pix_x_q <= cfg_pix_x;
        pix_y_q <= cfg_pix_y;
        cys_q   <= cfg_cys;
        dcx_q   <= cfg_dcx;
        dcy_q   <= cfg_dcy;
        max_q   <= cfg_max_iter;
        px_q    <= '0;
        py_q    <= '0;
        cx_q    <= cfg_cxs;
        cy_q    <= cfg_cys;
        if (cfg_empty) begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          job_valid_q <= 1'b0;
          done_q      <= 1'b1;
        end else begin
          state_q     <= S_ISSUE;
          busy_q      <= 1'b1;
          job_valid_q <= 1'b1;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            job_valid_q <= 1'b0;
          end
          S_ISSUE: begin
            if (job_valid_q && eng.job_ready) begin
              job_valid_q <= 1'b0;
              state_q     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (eng.res_valid) begin
              we_q    <= 1'b1;
              wx_q    <= px_q;
              wy_q    <= py_q;
              wd_q    <= wd_map;
              state_q <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (last_pix_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              px_q        <= px_d;
              py_q        <= py_d;
              cx_q        <= cx_d;
              cy_q        <= cy_d;
              job_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign eng.job_valid = job_valid_q;
  assign eng.job_cx    = cx_q;
  assign eng.job_cy    = cy_q;
  assign eng.job_max   = max_q;
  assign eng.eng_abort = abort_q;
  assign wx            = wx_q;
  assign wy            = wy_q;
  assign wd            = wd_q;
  assign we            = we_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Directed bench for mandel_scan_ctrl with a behavioural iteration engine.
module tb_mandel_scan_ctrl;

  logic               clk;
  logic               rst_n;
  logic               cfg_start;
  logic [8:0]         cfg_pix_x;
  logic [7:0]         cfg_pix_y;
  logic signed [15:0] cfg_cxs, cfg_cys, cfg_dcx, cfg_dcy;
  logic [15:0]        cfg_max_iter;
  logic [8:0]         wx;
  logic [7:0]         wy;
  logic [2:0]         wd;
  logic               we, busy, done;

  mandel_scan_ctrl_if eng ();

  mandel_scan_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_pix_x    (cfg_pix_x),
    .cfg_pix_y    (cfg_pix_y),
    .cfg_cxs      (cfg_cxs),
    .cfg_cys      (cfg_cys),
    .cfg_dcx      (cfg_dcx),
    .cfg_dcy      (cfg_dcy),
    .cfg_max_iter (cfg_max_iter),
    .eng          (eng),
    .wx           (wx),
    .wy           (wy),
    .wd           (wd),
    .we           (we),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Engine model controls.
  logic        eng_en;
  int          eng_lat;
  logic [15:0] eng_iter;

  // Observed traffic.
  logic [31:0] job_q[$];
  logic [31:0] wr_q[$];
  int          done_cnt;
  int          abort_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_pack(input int x, input int y, input int d);
    logic [8:0] xx;
    logic [7:0] yy;
    logic [2:0] dd;
    xx = 9'(x);
    yy = 8'(y);
    dd = 3'(d);
    return {12'd0, xx, yy, dd};
  endfunction

  // Monitor: record jobs that will transfer at the next edge, writes and pulses.
  initial begin
    done_cnt  = 0;
    abort_cnt = 0;
    forever begin
      @(negedge clk);
      if (eng.job_valid && eng.job_ready) job_q.push_back({eng.job_cx, eng.job_cy});
      if (we) wr_q.push_back({12'd0, wx, wy, wd});
      if (done) done_cnt++;
      if (eng.eng_abort) abort_cnt++;
    end
  end

  // Engine: answer each accepted job eng_lat cycles later with eng_iter.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!eng_en || eng.eng_abort) cnt = 0;
      if (eng_en && eng.job_valid && eng.job_ready) cnt = eng_lat;
      @(posedge clk);
      #3;
      if (eng_en) begin
        eng.res_valid = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            eng.res_valid = 1'b1;
            eng.res_iter  = eng_iter;
          end
        end
      end
    end
  end

  task automatic start_frame(input int px, input int py, input logic [15:0] cxs,
                             input logic [15:0] cys, input logic [15:0] dcx,
                             input logic [15:0] dcy, input logic [15:0] mx);
    @(posedge clk);
    #1;
    cfg_pix_x    = 9'(px);
    cfg_pix_y    = 8'(py);
    cfg_cxs      = cxs;
    cfg_cys      = cys;
    cfg_dcx      = dcx;
    cfg_dcy      = dcy;
    cfg_max_iter = mx;
    cfg_start    = 1'b1;
    @(posedge clk);
    #1;
    cfg_start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    check_val(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_jobs(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (job_q.size() < target && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    check_val(tag, 32'(job_q.size() >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int jb, wb, dc, ab;
    int iters[4];
    int wds[4];
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_pix_x = '0;
    cfg_pix_y = '0;
    cfg_cxs = '0;
    cfg_cys = '0;
    cfg_dcx = '0;
    cfg_dcy = '0;
    cfg_max_iter = '0;
    eng.job_ready = 1'b0;
    eng.res_valid = 1'b0;
    eng.res_iter = '0;
    eng_en = 1'b0;
    eng_lat = 2;
    eng_iter = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_job_valid", 32'(eng.job_valid), 32'd0);
    check_val("rst_we", 32'(we), 32'd0);
    check_val("rst_abort", 32'(eng.eng_abort), 32'd0);
    check_val("rst_wxywd", {12'd0, wx, wy, wd}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2x2 frame, engine answers 3 after 2 cycles
    eng.job_ready = 1'b1;
    eng_en = 1'b1;
    eng_lat = 2;
    eng_iter = 16'd3;
    start_frame(2, 2, 16'hE000, 16'hF000, 16'h0040, 16'h0040, 16'd100);
    @(negedge clk);
    check_val("f1_busy_start", 32'(busy), 32'd1);
    wait_done("f1_done_tmo", 1, 200);
    check_val("f1_njobs", 32'(job_q.size()), 32'd4);
    check_val("f1_job0", job_q[0], 32'hE000F000);
    check_val("f1_job1", job_q[1], 32'hE000F040);
    check_val("f1_job2", job_q[2], 32'hE040F000);
    check_val("f1_job3", job_q[3], 32'hE040F040);
    check_val("f1_nwr", 32'(wr_q.size()), 32'd4);
    check_val("f1_wr0", wr_q[0], wr_pack(0, 0, 4));
    check_val("f1_wr1", wr_q[1], wr_pack(0, 1, 4));
    check_val("f1_wr2", wr_q[2], wr_pack(1, 0, 4));
    check_val("f1_wr3", wr_q[3], wr_pack(1, 1, 4));
    repeat (3) @(negedge clk);
    check_val("f1_done_cnt", 32'(done_cnt), 32'd1);
    check_val("f1_busy_end", 32'(busy), 32'd0);

    // Backpressure: job held stable while job_ready is low
    eng.job_ready = 1'b0;
    eng_iter = 16'd100;
    jb = job_q.size();
    wb = wr_q.size();
    dc = done_cnt;
    start_frame(1, 1, 16'h1234, 16'h5678, 16'h0001, 16'h0001, 16'd100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_valid", 32'(eng.job_valid), 32'd1);
      check_val("stall_cx", {16'd0, eng.job_cx}, 32'h1234);
      check_val("stall_cy", {16'd0, eng.job_cy}, 32'h5678);
    end
    check_val("stall_max", {16'd0, eng.job_max}, 32'd100);
    @(posedge clk);
    #2;
    check_val("stall_nojob", 32'(job_q.size()), 32'(jb));
    check_val("stall_nowr", 32'(wr_q.size()), 32'(wb));
    #1;
    eng.job_ready = 1'b1;
    wait_done("stall_done_tmo", dc + 1, 100);
    check_val("stall_wr", wr_q[wb], wr_pack(0, 0, 0));

    // Colour map
    iters = '{7, 6, 99, 0};
    wds   = '{1, 7, 2, 1};
    for (int i = 0; i < 4; i++) begin
      wb = wr_q.size();
      dc = done_cnt;
      eng_iter = 16'(iters[i]);
      start_frame(1, 1, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'd100);
      wait_done("cmap_done_tmo", dc + 1, 100);
      check_val($sformatf("cmap_wd_%0d", iters[i]), wr_q[wb], wr_pack(0, 0, wds[i]));
    end

    // Empty frame: immediate done, no jobs, no writes
    jb = job_q.size();
    wb = wr_q.size();
    start_frame(0, 3, 16'h0100, 16'h0100, 16'h0001, 16'h0001, 16'd100);
    @(negedge clk);
    check_val("empty_done", 32'(done), 32'd1);
    check_val("empty_busy", 32'(busy), 32'd0);
    check_val("empty_jv", 32'(eng.job_valid), 32'd0);
    @(negedge clk);
    check_val("empty_done_pulse", 32'(done), 32'd0);
    start_frame(4, 0, 16'h0100, 16'h0100, 16'h0001, 16'h0001, 16'd100);
    @(negedge clk);
    check_val("empty_y_done", 32'(done), 32'd1);
    repeat (5) @(posedge clk);
    #2;
    check_val("empty_nojob", 32'(job_q.size()), 32'(jb));
    check_val("empty_nowr", 32'(wr_q.size()), 32'(wb));

    // Restart while waiting on pixel (1,0)
    jb = job_q.size();
    wb = wr_q.size();
    dc = done_cnt;
    ab = abort_cnt;
    eng_lat = 20;
    eng_iter = 16'd3;
    start_frame(2, 2, 16'hE000, 16'hF000, 16'h0040, 16'h0040, 16'd100);
    wait_jobs("abort_jobs_tmo", jb + 3, 200);
    check_val("abort_job10", job_q[jb + 2], 32'hE040F000);
    eng_lat = 2;
    eng_iter = 16'd12;
    start_frame(1, 1, 16'h0100, 16'h0200, 16'h0001, 16'h0001, 16'd100);
    wait_done("abort_done_tmo", dc + 1, 200);
    repeat (3) @(posedge clk);
    #2;
    check_val("abort_pulses", 32'(abort_cnt - ab), 32'd1);
    check_val("abort_njobs", 32'(job_q.size() - jb), 32'd4);
    check_val("abort_newjob", job_q[jb + 3], 32'h01000200);
    check_val("abort_nwr", 32'(wr_q.size() - wb), 32'd3);
    check_val("abort_wr0", wr_q[wb], wr_pack(0, 0, 4));
    check_val("abort_wr1", wr_q[wb + 1], wr_pack(0, 1, 4));
    check_val("abort_wr_new", wr_q[wb + 2], wr_pack(0, 0, 6));
    check_val("abort_done_cnt", 32'(done_cnt - dc), 32'd1);

    // Reset during WAIT, then a stale result
    jb = job_q.size();
    eng_lat = 30;
    eng_iter = 16'd5;
    start_frame(2, 2, 16'h0300, 16'h0400, 16'h0010, 16'h0010, 16'd100);
    wait_jobs("rstw_jobs_tmo", jb + 1, 100);
    repeat (2) @(posedge clk);
    #1;
    check_val("rstw_busy_pre", 32'(busy), 32'd1);
    wb = wr_q.size();
    dc = done_cnt;
    ab = abort_cnt;
    rst_n = 1'b0;
    #1;
    check_val("rstw_busy", 32'(busy), 32'd0);
    check_val("rstw_jv", 32'(eng.job_valid), 32'd0);
    check_val("rstw_we_done_abort", {29'd0, we, done, eng.eng_abort}, 32'd0);
    check_val("rstw_wxywd", {12'd0, wx, wy, wd}, 32'd0);
    eng_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    eng.res_valid = 1'b1;
    eng.res_iter = 16'd5;
    @(posedge clk);
    #1;
    eng.res_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_val("rstw_nowr", 32'(wr_q.size()), 32'(wb));
    check_val("rstw_nodone", 32'(done_cnt), 32'(dc));
    check_val("rstw_noabort", 32'(abort_cnt), 32'(ab));
    check_val("rstw_nojob", 32'(job_q.size()), 32'(jb + 1));
    check_val("rstw_idle", {30'd0, busy, eng.job_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mandel_scan_ctrl.md
MANDEL_SCAN_CTRL -- requirements
Module: mandel_scan_ctrl

Interface
REQ-001 Parameter N_BIT, default 16, width of signed Q4.12 fixed-point coordinates.
REQ-002 Parameter W_IT, default 16, iteration-count width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cfg_start  input  1  one-cycle pulse that latches all cfg_* inputs and starts a frame.
REQ-006 cfg_pix_x  input  9  column count; cfg_pix_y input 8 row count.
REQ-007 cfg_cxs, cfg_cys  input  N_BIT each  c of pixel (0,0).
REQ-008 cfg_dcx, cfg_dcy  input  N_BIT each  per-column and per-row c step.
REQ-009 cfg_max_iter  input  W_IT  iteration limit passed to engine.
REQ-010 job_valid  output 1; job_ready input 1; job_cx, job_cy output N_BIT; job_max output W_IT: job handshake to iteration engine.
REQ-011 res_valid  input 1; res_iter input W_IT: engine result, one-cycle pulse.
REQ-012 eng_abort  output  1  one-cycle pulse telling engine to drop its current job.
REQ-013 wx output 9, wy output 8, wd output 3, we output 1: framebuffer pixel write.
REQ-014 busy  output 1  high while a frame is in progress; done output 1 one-cycle pulse at frame end.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, WRITE; IDLE on reset.
REQ-016 IDLE + cfg_start: latch config, px=0, py=0, cx=cfg_cxs, cy=cfg_cys; next ISSUE, busy=1 next cycle.
REQ-017 IDLE + cfg_start with cfg_pix_x==0 or cfg_pix_y==0: stay IDLE, pulse done next cycle, no jobs, no writes.
REQ-018 ISSUE: job_valid=1 with job_cx=cx, job_cy=cy, job_max=latched max; job fields stable while job_valid && !job_ready.
REQ-019 Job transfer on job_valid && job_ready; next WAIT, job_valid=0.
REQ-020 WAIT: on res_valid capture res_iter, next WRITE; res_valid outside WAIT is ignored.
REQ-021 WRITE (one cycle): we=1, wx=px, wy=py, wd=0 if res_iter>=max else (res_iter mod 7)+1.
REQ-022 Scan order column-major: py increments, cy+=dcy; at py==pix_y-1 py=0, cy=cys, px increments, cx+=dcx.
REQ-023 After WRITE of pixel (pix_x-1, pix_y-1): next IDLE, done=1 for one cycle, busy=0.
REQ-024 Otherwise WRITE -> ISSUE; minimum period per pixel = 3 cycles plus engine latency.
REQ-025 Coordinate adds wrap modulo 2^N_BIT, no saturation.
REQ-026 cfg_start in ISSUE/WAIT/WRITE: eng_abort pulses if state is WAIT, no write for the current pixel, config relatched, restart at (0,0) in ISSUE; no done for the aborted frame.
REQ-027 cfg_start and res_valid in the same WAIT cycle: restart wins, result discarded.
REQ-028 we, done, eng_abort are single-cycle pulses; wx/wy/wd only meaningful when we=1.

Reset
REQ-029 rst_n low: state=IDLE; job_valid, we, done, busy, eng_abort=0; wx, wy, wd, px, py, cx, cy, latched config=0, asynchronously.
REQ-030 Reset mid-frame abandons the frame with no write and no done; first post-reset activity only after cfg_start.

Structure
REQ-031 Shared package holds N_BIT, FRAC=12, W_IT, pixel widths, FSM state encoding, and color-map function.
REQ-032 One sub-module, mandel_color_map (res_iter, max -> wd), combinational.

Verification
REQ-033 2x2 frame, cxs=0xE000, cys=0xF000, dcx=dcy=0x0040, job_ready=1, engine returns 3 after 2 cycles -> jobs (E000,F000),(E000,F040),(E040,F000),(E040,F040); 4 writes wd=4; single done.
REQ-034 job_ready held low 5 cycles -> job_valid and job_cx/cy stable, no WAIT entry until ready.
REQ-035 max=100, res_iter=100 -> wd=0; res_iter=7 -> wd=1; res_iter=6 -> wd=7.
REQ-036 cfg_pix_x=0 with cfg_start -> done one cycle later, no job_valid, no we.
REQ-037 cfg_start while WAIT on pixel (1,0) -> eng_abort pulse, no write, next job at new cfg_cxs/cfg_cys.
REQ-038 rst_n low during WAIT -> all outputs 0 immediately; late res_valid after release -> no write.
